// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM encoding and nibble helpers for the binary/BCD converters.
package bcd_pkg;

    // Width of one packed BCD digit.
    localparam int NIB_W      = 4;
    // Double-dabble correction: a nibble at or above this value is about to carry past 9 when doubled.
    localparam int ADJ_THRESH = 5;
    // Correction added to such a nibble before the shift.
    localparam int ADJ_ADD    = 3;
    // Largest legal value of a BCD digit. BCD2bin checks use this as well.
    localparam int DIGIT_MAX  = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True when a nibble must be corrected before the next doubling.
    function automatic logic nib_needs_adjust(input logic [NIB_W-1:0] nib);
        return nib >= NIB_W'(ADJ_THRESH);
    endfunction

    // True when a nibble holds a legal decimal digit.
    function automatic logic nib_is_digit(input logic [NIB_W-1:0] nib);
        return nib <= NIB_W'(DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-nibble conditional add-3 cell used by the shift-add-3 converter.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [NIB_W-1:0] nib_in,
    output logic [NIB_W-1:0] nib_out
);

    // A nibble of 5..9 gets +3 so the following left shift carries into the next digit.
    always_comb begin
        nib_out = nib_in;
        if (nib_needs_adjust(nib_in)) begin
            nib_out = nib_in + NIB_W'(ADJ_ADD);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (double dabble), one bit per clock.
// An extra internal digit above the DIGITS output digits catches values >= 10^DIGITS.
// That digit drives ovf. bcdOut carries the result mod 10^DIGITS.
// BIN_W must not exceed 3*(DIGITS+1), or the scratch register would be too narrow.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          binIn,
    output logic                      busy,
    output logic                      done,
    output logic [NIB_W*DIGITS-1:0]   bcdOut,
    output logic                      ovf
);

    localparam int SCR_W = NIB_W * (DIGITS + 1);
    localparam int OUT_W = NIB_W * DIGITS;
    localparam int CAT_W = SCR_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t             state;
    state_t             state_nxt;
    logic [BIN_W-1:0]   shift_reg;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   count;
    logic [CAT_W-1:0]   cat_shifted;
    logic               accept;
    logic               last_iter;

    // All scratch digits, including the internal overflow digit, are corrected in parallel.
    for (genvar g = 0; g <= DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .nib_in  (scratch[g*NIB_W +: NIB_W]),
            .nib_out (scratch_adj[g*NIB_W +: NIB_W])
        );
    end

    // One double-dabble step: shift the corrected scratch and the remaining binary bits left together.
    assign cat_shifted = {scratch_adj, shift_reg} << 1;

    assign accept    = (state == IDLE) && start;
    assign last_iter = (state == SHIFT) && (count == LAST_CNT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A start that arrives while busy is dropped and not remembered.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (count == LAST_CNT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are plain decodes of the state register, so start has no combinational path to them.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Iteration datapath: load on accept, then one shift per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
        end else if (accept) begin
            shift_reg <= binIn;
            scratch   <= '0;
            count     <= '0;
        end else if (state == SHIFT) begin
            scratch   <= cat_shifted[CAT_W-1 -: SCR_W];
            shift_reg <= cat_shifted[BIN_W-1:0];
            count     <= count + 1'b1;
        end
    end

    // Result registers take the post-shift scratch only on the final iteration, so intermediate values never appear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcdOut <= '0;
            ovf    <= 1'b0;
        end else if (last_iter) begin
            bcdOut <= cat_shifted[BIN_W +: OUT_W];
            ovf    <= |cat_shifted[CAT_W-1 -: NIB_W];
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: the driver queues expected results and the monitor checks each done pulse.
module tb_bin2bcd_seq;

    localparam int BIN_W  = 7;
    localparam int DIGITS = 2;
    localparam int OUT_W  = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [BIN_W-1:0]  binIn = '0;
    logic              busy;
    logic              done;
    logic [OUT_W-1:0]  bcdOut;
    logic              ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int               val;
        logic [OUT_W-1:0] bcd;
        logic             ovf;
        int               cyc;
    } exp_t;

    exp_t sb[$];

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .binIn  (binIn),
        .busy   (busy),
        .done   (done),
        .bcdOut (bcdOut),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Decimal reference: the low DIGITS decimal digits of v, packed as nibbles.
    function automatic logic [OUT_W-1:0] ref_bcd(input int v);
        logic [OUT_W-1:0] r;
        int rem;
        r   = '0;
        rem = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int v);
        int lim;
        lim = 1;
        for (int d = 0; d < DIGITS; d++) lim = lim * 10;
        return v >= lim;
    endfunction

    // Behaviour of the companion BCD2bin decoder, used for the round-trip check.
    function automatic int bcd_to_bin(input logic [OUT_W-1:0] b);
        int r;
        r = 0;
        for (int d = DIGITS - 1; d >= 0; d--) r = r * 10 + int'(b[d*4 +: 4]);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push_exp(input int v, input int e0);
        exp_t e;
        e.val = v;
        e.bcd = ref_bcd(v);
        e.ovf = ref_ovf(v);
        e.cyc = e0 + BIN_W;
        sb.push_back(e);
    endtask

    // Call at a negedge. Returns at a negedge with the DUT idle, or reports a timeout.
    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("wait_idle", int'(busy), 0);
    endtask

    // Call at a negedge. Issues one accepted conversion and returns at the negedge after the sampling edge.
    task automatic issue(input int v);
        wait_idle();
        start = 1'b1;
        binIn = BIN_W'(v);
        push_exp(v, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        binIn = BIN_W'($urandom);
    endtask

    // Monitor: every done pulse pops one expectation. Between pulses the outputs must hold.
    initial begin : monitor
        logic [OUT_W-1:0] last_bcd;
        logic             last_ovf;
        exp_t             e;
        last_bcd = '0;
        last_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_bcd = '0;
                last_ovf = 1'b0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("bcdOut(%0d)", e.val), int'(bcdOut), int'(e.bcd));
                    check($sformatf("ovf(%0d)", e.val), int'(ovf), int'(e.ovf));
                    check($sformatf("latency(%0d)", e.val), cyc, e.cyc);
                    check($sformatf("roundtrip(%0d)", e.val), bcd_to_bin(bcdOut), e.val % (10 ** DIGITS));
                end
                last_bcd = bcdOut;
                last_ovf = ovf;
            end else begin
                check("hold_bcdOut", int'(bcdOut), int'(last_bcd));
                check("hold_ovf", int'(ovf), int'(last_ovf));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n_busy;
        int w;
        int order[$];

        // Outputs while reset is held.
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bcdOut", int'(bcdOut), 0);
        check("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round trip and boundaries.
        issue(87);
        issue(0);
        issue(99);
        issue(100);
        issue(127);
        wait_idle();

        // Busy lockout: a second start during SHIFT is ignored. Busy lasts BIN_W+1 cycles.
        issue(42);
        n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            n_busy++;
            if (i == 2) begin
                start = 1'b1;
                binIn = BIN_W'(13);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", n_busy, BIN_W + 1);
        @(negedge clk);

        // Back-to-back with start held high; binIn steps at each done.
        wait_idle();
        start = 1'b1;
        binIn = BIN_W'(10);
        push_exp(10, cyc + 1);
        for (int k = 1; k <= 3; k++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!done && w < 30);
            check("b2b_done_seen", int'(done), 1);
            if (k < 3) begin
                binIn = BIN_W'(10 + k);
                push_exp(10 + k, cyc + 2);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);

        // Asynchronous reset in the middle of SHIFT, between clock edges.
        issue(127);
        issue(64);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_bcdOut", int'(bcdOut), 0);
        check("arst_ovf", int'(ovf), 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        binIn = BIN_W'(55);
        push_exp(55, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Full sweep in shuffled order with random idle gaps.
        for (int v = 0; v < (1 << BIN_W); v++) order.push_back(v);
        order.shuffle();
        foreach (order[i]) begin
            issue(order[i]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Extra random operands.
        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(0, (1 << BIN_W) - 1)));
        end

        // Drain outstanding expectations.
        w = 0;
        while (sb.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("drain_scoreboard", sb.size(), 0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
